// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: hazard controller for the 5-stage RV32I pipeline.
// Tracks register/control fields through E, M and W in shadow registers,
// drives the two Execute operand-forwarding selects, and produces the
// stall/flush controls for the F, D and E pipeline registers.
// Optional macro HAZARD_PERF_EN adds saturating load-use stall and
// branch flush counters (stall_cnt, flush_cnt) and the CNT_W parameter.
module hazard_fwd_ctrl #(
  parameter int REG_AW = 5
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              reg_write_d,
  input  logic              is_load_d,
  input  logic              pc_src_e,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e
`ifdef HAZARD_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  // Execute-stage shadow fields
  logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
  logic              reg_write_e, load_e;
  // Memory-stage shadow fields
  logic [REG_AW-1:0] rd_m;
  logic              reg_write_m;
  // Writeback-stage shadow fields
  logic [REG_AW-1:0] rd_w;
  logic              reg_write_w;

  logic              lw_stall;
  logic              bubble_e;

  // Forward select for one operand: M result wins over W; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rdm,
    input logic              wm,
    input logic [REG_AW-1:0] rdw,
    input logic              ww
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wm && (rdm != '0) && (rdm == rs))
      sel = 2'b10;
    else if (ww && (rdw != '0) && (rdw == rs))
      sel = 2'b01;
    return sel;
  endfunction

  // Hazard detection and gated outputs; everything is forced low in reset.
  always_comb begin
    lw_stall    = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    bubble_e    = lw_stall || pc_src_e;
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    if (!reset) begin
      forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
      forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
      stall_f     = lw_stall;
      stall_d     = lw_stall;
      flush_d     = pc_src_e;
      flush_e     = bubble_e;
    end
  end

  // Shadow pipeline: D->E (bubbled on flush), then E->M->W every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      reg_write_e <= 1'b0;
      load_e      <= 1'b0;
      rd_m        <= '0;
      reg_write_m <= 1'b0;
      rd_w        <= '0;
      reg_write_w <= 1'b0;
    end else begin
      if (bubble_e) begin
        rs1_e       <= '0;
        rs2_e       <= '0;
        rd_e        <= '0;
        reg_write_e <= 1'b0;
        load_e      <= 1'b0;
      end else begin
        rs1_e       <= rs1_d;
        rs2_e       <= rs2_d;
        rd_e        <= rd_d;
        reg_write_e <= reg_write_d;
        load_e      <= is_load_d;
      end
      // ---- E -> M ----
      rd_m        <= rd_e;
      reg_write_m <= reg_write_e;
      // ---- M -> W ----
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Performance counters for load-use stalls and branch flushes
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (lw_stall) stall_q <= sat_inc(stall_q);
      if (pc_src_e) flush_q <= sat_inc(flush_q);
    end
  end

  assign stall_cnt = reset ? '0 : stall_q;
  assign flush_cnt = reset ? '0 : flush_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed testbench for hazard_fwd_ctrl: drives a short instruction
// sequence into Decode and checks forwarding/stall/flush each cycle
// against hand-computed values.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       reg_write_d, is_load_d, pc_src_e;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, flush_d, flush_e;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hazard_fwd_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rd_d        (rd_d),
    .reg_write_d (reg_write_d),
    .is_load_d   (is_load_d),
    .pc_src_e    (pc_src_e),
    .forward_a_e (forward_a_e),
    .forward_b_e (forward_b_e),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .flush_e     (flush_e)
`ifdef HAZARD_PERF_EN
    , .stall_cnt (stall_cnt)
    , .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one Decode instruction just after the rising edge, then wait
  // for the falling edge so checks sample settled outputs.
  task automatic cyc(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                     input logic rw, input logic ld, input logic br);
    @(posedge clk);
    #1;
    rs1_d = r1; rs2_d = r2; rd_d = rd;
    reg_write_d = rw; is_load_d = ld; pc_src_e = br;
    @(negedge clk);
  endtask

  task automatic nop();
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_ctl(input string tag, input logic sf, input logic sd,
                         input logic fd, input logic fe);
    check({tag, ".stall_f"}, {31'd0, stall_f}, {31'd0, sf});
    check({tag, ".stall_d"}, {31'd0, stall_d}, {31'd0, sd});
    check({tag, ".flush_d"}, {31'd0, flush_d}, {31'd0, fd});
    check({tag, ".flush_e"}, {31'd0, flush_e}, {31'd0, fe});
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] fa, input logic [1:0] fb);
    check({tag, ".fwd_a"}, {30'd0, forward_a_e}, {30'd0, fa});
    check({tag, ".fwd_b"}, {30'd0, forward_b_e}, {30'd0, fb});
  endtask

  initial begin
    reset = 1'b1;
    rs1_d = 5'd8; rs2_d = 5'd2; rd_d = 5'd9;
    reg_write_d = 1'b1; is_load_d = 1'b0; pc_src_e = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_fwd("reset", 2'b00, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pc_src_e = 1'b0;
    @(negedge clk);
    nop();

    // Back-to-back ALU dependency: add x5,x1,x2 ; sub x6,x5,x3
    cyc(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc(5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0);
    chk_ctl("b2b_d", 1'b0, 1'b0, 1'b0, 1'b0);
    nop();
    chk_fwd("b2b", 2'b10, 2'b00);
    chk_ctl("b2b_e", 1'b0, 1'b0, 1'b0, 1'b0);
    nop();

    // Distance-2: add x5 ; nop ; or x7,x4,x5 -> B from W
    cyc(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    nop();
    cyc(5'd4, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0);
    nop();
    chk_fwd("dist2", 2'b00, 2'b01);

    // M and W both write x5 -> M wins
    cyc(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc(5'd1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc(5'd4, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0);
    nop();
    chk_fwd("mprio", 2'b00, 2'b10);

    // Load-use: lw x8,0(x1) ; add x9,x8,x2 -> one bubble, then A from W
    cyc(5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
    cyc(5'd8, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
    chk_ctl("lu_stall", 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(5'd8, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
    chk_ctl("lu_after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_fwd("lu_bubble", 2'b00, 2'b00);
`ifdef HAZARD_PERF_EN
    check("lu_stall_cnt", stall_cnt, 32'd1);
`endif
    nop();
    chk_fwd("lu_fwd", 2'b01, 2'b00);

    // x0 destination: add x0,x1,x2 ; add x3,x0,x0
    cyc(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    nop();
    chk_fwd("x0_m", 2'b00, 2'b00);
    nop();
    // lw x0 followed by a use of x0
    cyc(5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    cyc(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    chk_ctl("x0_lw", 1'b0, 1'b0, 1'b0, 1'b0);
    nop();
    chk_fwd("x0_lw_m", 2'b00, 2'b00);

    // Taken branch: add x5 in D is flushed and must not forward later
    cyc(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1);
    chk_ctl("br", 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    chk_ctl("br_next", 1'b0, 1'b0, 1'b0, 1'b0);
    nop();
    chk_fwd("br_bubble", 2'b00, 2'b00);

    // Branch coinciding with a load-use hazard
    cyc(5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
    cyc(5'd8, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1);
    chk_ctl("br_lu", 1'b1, 1'b1, 1'b1, 1'b1);
`ifdef HAZARD_PERF_EN
    check("br_lu_stall_cnt", stall_cnt, 32'd1);
    check("br_lu_flush_cnt", flush_cnt, 32'd1);
`endif
    nop();
    chk_ctl("br_lu_next", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_EN
    check("stall_cnt_tot", stall_cnt, 32'd2);
    check("flush_cnt_tot", flush_cnt, 32'd2);
`endif

    // Reset while a load-use hazard is pending
    cyc(5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    rs1_d = 5'd8; rs2_d = 5'd2; rd_d = 5'd9;
    reg_write_d = 1'b1; is_load_d = 1'b0; pc_src_e = 1'b0;
    @(negedge clk);
    chk_ctl("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_fwd("rst_mid", 2'b00, 2'b00);
`ifdef HAZARD_PERF_EN
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    rs1_d = 5'd0; rs2_d = 5'd0; rd_d = 5'd0;
    reg_write_d = 1'b0; is_load_d = 1'b0;
    @(negedge clk);
    chk_ctl("rst_after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_fwd("rst_after", 2'b00, 2'b00);
    // Same pending consumer in D after reset must not stall
    cyc(5'd8, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
    chk_ctl("rst_cleared", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
